// File: rtl/rc5_pkg.sv
// Shared types and constants for the RC5-style stream decryptor.
// Used by rc5_sbox_gen and rc5_dec_stream (optional counter: RC5_DEC_BLKCNT_EN).
package rc5_pkg;

  localparam int H  = 8;
  localparam int RW = $clog2(H);

  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] SEED_ZERO_SUB = 8'h01;

  typedef enum logic [2:0] {
    NOKEY  = 3'd0,
    KEYGEN = 3'd1,
    IDLE   = 3'd2,
    RND_B  = 3'd3,
    RND_A  = 3'd4,
    FINAL  = 3'd5,
    HOLD   = 3'd6
  } state_e;

  function automatic logic [H-1:0] rotr(input logic [H-1:0] x, input logic [RW-1:0] n);
    logic [2*H-1:0] dbl;
    dbl = {x, x} >> n;
    return dbl[H-1:0];
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], ^(x & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rc5_sbox_gen.sv
// Key-table generator: an 8-bit LFSR filling one S entry per cycle while gen_en is high.
module rc5_sbox_gen
  import rc5_pkg::*;
#(
  parameter int R = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     key_load,
  input  logic [7:0]               key_seed,
  input  logic                     gen_en,
  output logic                     gen_last,
  output logic [2*R+1:0][H-1:0]    s_tab
);

  localparam int KD = 2 * R + 2;
  localparam int KW = $clog2(KD);

  logic [7:0]             lfsr_q, lfsr_d;
  logic [KW-1:0]          idx_q, idx_d;
  logic [2*R+1:0][H-1:0]  s_q, s_d;

  always_comb begin
    lfsr_d = lfsr_q;
    idx_d  = idx_q;
    s_d    = s_q;
    if (key_load) begin
      // An all-zero seed would lock the LFSR, so it is replaced.
      lfsr_d = (key_seed == 8'h00) ? SEED_ZERO_SUB : key_seed;
      idx_d  = '0;
    end else if (gen_en) begin
      s_d[idx_q] = lfsr_q;
      lfsr_d     = lfsr_next(lfsr_q);
      idx_d      = idx_q + KW'(1);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= 8'h01;
      idx_q  <= '0;
      s_q    <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      idx_q  <= idx_d;
      s_q    <= s_d;
    end
  end

  assign gen_last = gen_en && (idx_q == KW'(KD - 1));
  assign s_tab    = s_q;

endmodule

// File: rtl/rc5_dec_stream.sv
// Streaming RC5-style block decryptor: one half-round per cycle, valid/ready on both sides.
// Define RC5_DEC_BLKCNT_EN to build the delivered-block counter on blk_count.
module rc5_dec_stream
  import rc5_pkg::*;
#(
  parameter int W = 16,
  parameter int R = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          key_load,
  input  logic [7:0]    key_seed,
  output logic          key_ready,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [15:0]   blk_count
);

  localparam int IW = $clog2(R + 1);
  localparam int KW = $clog2(2 * R + 2);

  state_e                 state_q, state_d;
  logic [H-1:0]           a_q, a_d, b_q, b_d;
  logic [IW-1:0]          i_q, i_d;
  logic                   key_ready_q, in_ready_q, out_valid_q;
  logic                   gen_en, gen_last;
  logic [2*R+1:0][H-1:0]  s_tab;

  rc5_sbox_gen #(.R(R)) u_sbox (
    .clock    (clock),
    .reset    (reset),
    .key_load (key_load),
    .key_seed (key_seed),
    .gen_en   (gen_en),
    .gen_last (gen_last),
    .s_tab    (s_tab)
  );

  assign gen_en = (state_q == KEYGEN);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    if (key_load) begin
      state_d = KEYGEN;
    end else begin
      case (state_q)
        NOKEY:  state_d = NOKEY;
        KEYGEN: state_d = gen_last ? IDLE : KEYGEN;
        IDLE: begin
          if (in_valid) begin
            a_d     = in_data[W-1:H];
            b_d     = in_data[H-1:0];
            i_d     = IW'(R);
            state_d = RND_B;
          end else begin
            state_d = IDLE;
          end
        end
        RND_B: begin
          b_d     = rotr(b_q - s_tab[{i_q, 1'b1}], a_q[RW-1:0]) ^ a_q;
          state_d = RND_A;
        end
        RND_A: begin
          a_d = rotr(a_q - s_tab[{i_q, 1'b0}], b_q[RW-1:0]) ^ b_q;
          if (i_q > IW'(1)) begin
            i_d     = i_q - IW'(1);
            state_d = RND_B;
          end else begin
            state_d = FINAL;
          end
        end
        FINAL: begin
          b_d     = b_q - s_tab[KW'(1)];
          a_d     = a_q - s_tab[KW'(0)];
          state_d = HOLD;
        end
        HOLD:    state_d = out_ready ? IDLE : HOLD;
        default: state_d = NOKEY;
      endcase
    end
  end

  // Handshake outputs are flopped from the next state so they track state_q exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= NOKEY;
      a_q         <= '0;
      b_q         <= '0;
      i_q         <= '0;
      key_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      i_q         <= i_d;
      key_ready_q <= (state_d != NOKEY) && (state_d != KEYGEN);
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == HOLD);
    end
  end

  assign key_ready = key_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = {a_q, b_q};

`ifdef RC5_DEC_BLKCNT_EN
  logic [15:0] blk_count_q, blk_count_d;

  always_comb begin
    blk_count_d = blk_count_q;
    if (key_load) begin
      blk_count_d = 16'h0000;
    end else if (out_valid_q && out_ready) begin
      blk_count_d = blk_count_q + 16'h0001;
    end else begin
      blk_count_d = blk_count_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blk_count_q <= 16'h0000;
    end else begin
      blk_count_q <= blk_count_d;
    end
  end

  assign blk_count = blk_count_q;
`else
  assign blk_count = 16'h0000;
`endif

endmodule

// File: tb/tb_rc5_dec_stream.sv
// Directed self-checking bench for rc5_dec_stream (W=16, R=3) with hand-computed vectors.
module tb_rc5_dec_stream;

`ifdef RC5_DEC_BLKCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        key_load;
  logic [7:0]  key_seed;
  logic        key_ready;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] blk_count;

  int          vec_cnt;
  int          err_cnt;
  logic [15:0] blk_exp;

  rc5_dec_stream #(.W(16), .R(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .key_load  (key_load),
    .key_seed  (key_seed),
    .key_ready (key_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .blk_count (blk_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_in_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL wait_in_ready: timed out, in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic check_blk(input string name);
    logic [15:0] exp;
    exp = CNT_EN ? blk_exp : 16'h0000;
    vec_cnt++;
    if (blk_count !== exp) begin
      err_cnt++;
      $display("FAIL %s blk_count: got %h expected %h", name, blk_count, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key_load = 1'b0; key_seed = 8'h00;
    in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
    blk_exp = 16'h0000;
    tick(); tick();
    vec_cnt++;
    if ({key_ready, in_ready, out_valid} !== 3'b000 || out_data !== 16'h0000) begin
      err_cnt++;
      $display("FAIL reset_outputs: got kr=%b ir=%b ov=%b od=%h expected 0 0 0 0000",
               key_ready, in_ready, out_valid, out_data);
    end
    check_blk("reset");
    reset = 1'b0;
    tick();
    vec_cnt++;
    if (key_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_release key_ready: got %b expected 0", key_ready);
    end
  endtask

  task automatic test_nokey_ignore();
    in_valid = 1'b1;
    in_data  = 16'h0000;
    for (int c = 0; c < 4; c++) begin
      tick();
      vec_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL nokey_ignore: got ir=%b ov=%b expected 0 0", in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  // Pulses key_load; key_ready/in_ready must stay low for 7 cycles and rise on the 8th.
  task automatic do_keyload(input logic [7:0] seed);
    key_seed = seed;
    key_load = 1'b1;
    in_valid = 1'b1;
    tick();
    key_load = 1'b0;
    blk_exp  = 16'h0000;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) tick();
      vec_cnt++;
      if (key_ready !== (c == 8) || in_ready !== (c == 8) || out_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL keygen seed=%h cycle %0d: got kr=%b ir=%b ov=%b expected %b %b 0",
                 seed, c, key_ready, in_ready, out_valid, (c == 8), (c == 8));
      end
    end
    in_valid = 1'b0;
    check_blk("keyload");
  endtask

  task automatic run_block(input logic [15:0] din, input logic [15:0] exp, input int hold);
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = din;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      vec_cnt++;
      if (out_valid !== (c == 7)) begin
        err_cnt++;
        $display("FAIL latency din=%h cycle %0d: out_valid=%b expected %b",
                 din, c, out_valid, (c == 7));
      end
    end
    vec_cnt++;
    if (out_data !== exp) begin
      err_cnt++;
      $display("FAIL decrypt din=%h: got %h expected %h", din, out_data, exp);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      vec_cnt++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL hold cycle %0d: got ov=%b od=%h ir=%b expected 1 %h 0",
                 h, out_valid, out_data, in_ready, exp);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    blk_exp   = blk_exp + 16'h0001;
    vec_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL out_handshake: got ov=%b ir=%b expected 0 1", out_valid, in_ready);
    end
    check_blk("block");
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    wait_in_ready();
    in_data   = 16'h1234;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      tick();
      exp_v = (k == 8) || (k == 17) || (k == 26);
      vec_cnt++;
      if (out_valid !== exp_v) begin
        err_cnt++;
        $display("FAIL back_to_back cycle %0d: out_valid=%b expected %b", k, out_valid, exp_v);
      end
      if (exp_v) begin
        vec_cnt++;
        if (out_data !== 16'hA844) begin
          err_cnt++;
          $display("FAIL back_to_back data cycle %0d: got %h expected a844", k, out_data);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    blk_exp   = blk_exp + 16'h0003;
    check_blk("back_to_back");
  endtask

  task automatic test_abort();
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = 16'h0000;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    do_keyload(8'h01);
    for (int c = 0; c < 6; c++) begin
      tick();
      vec_cnt++;
      if (out_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL abort cycle %0d: out_valid=%b expected 0", c, out_valid);
      end
    end
    run_block(16'h0000, 16'h3FFD, 0);
  endtask

  task automatic test_reset_mid();
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    blk_exp = 16'h0000;
    vec_cnt++;
    if ({key_ready, in_ready, out_valid} !== 3'b000 || out_data !== 16'h0000) begin
      err_cnt++;
      $display("FAIL reset_mid outputs: got kr=%b ir=%b ov=%b od=%h expected 0 0 0 0000",
               key_ready, in_ready, out_valid, out_data);
    end
    check_blk("reset_mid");
    reset    = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      vec_cnt++;
      if (in_ready !== 1'b0 || key_ready !== 1'b0 || out_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_mid nokey cycle %0d: got ir=%b kr=%b ov=%b expected 0 0 0",
                 c, in_ready, key_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    do_keyload(8'h01);
    run_block(16'h0000, 16'h3FFD, 0);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_nokey_ignore();
    do_keyload(8'h01);
    run_block(16'h0000, 16'h3FFD, 0);
    run_block(16'h1234, 16'hA844, 0);
    run_block(16'h0000, 16'h3FFD, 5);
    test_back_to_back();
    do_keyload(8'h5A);
    do_keyload(8'h00);
    run_block(16'h0000, 16'h3FFD, 0);
    run_block(16'h1234, 16'hA844, 0);
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
